// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 64-point FFT output path.
//   FFT_POINTS   : frame length (2**LOG2N)
//   LOG2N        : bin index width
//   SAMPLE_WIDTH : default width of one real/imag component
//   sample_t     : one complex sample {re, im}
//   rd_state_e   : read-side FSM states of the output reorder buffer
//   bitrev()     : reverses the low n bits of an index
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_POINTS   = 64;
  localparam int LOG2N        = 6;
  localparam int SAMPLE_WIDTH = 16;

  typedef struct packed {
    logic [SAMPLE_WIDTH-1:0] re;
    logic [SAMPLE_WIDTH-1:0] im;
  } sample_t;

  typedef enum logic {
    RD_IDLE,
    RD_READ
  } rd_state_e;

  // Reverse all LOG2N bits, then shift down so only the low n bits are
  // reversed in place (n == LOG2N gives the plain full-width reversal).
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx,
                                              input int unsigned      n);
    logic [LOG2N-1:0] full;
    full = '0;
    for (int i = 0; i < LOG2N; i++) begin
      full[i] = idx[LOG2N-1-i];
    end
    return full >> (LOG2N - int'(n));
  endfunction

endpackage

// File: rtl/fft64_out_reorder_if.sv
// ---------------------------------------------------------------------------
// fft64_out_reorder_if
// Sample streams around the FFT output reorder buffer.
//   In_en/In_real/In_img          : bit-reversed input stream from the SDF chain
//   Out_en/Out_real/Out_img       : natural-order output stream
//   Out_idx                       : bin index of the current output sample
//   Out_last                      : marks bin FFT_POINTS-1
// Modports:
//   master : upstream/consumer side (drives In_*, observes Out_*)
//   slave  : the reorder block (consumes In_*, drives Out_*)
// ---------------------------------------------------------------------------
interface fft64_out_reorder_if #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 6
);

  logic             In_en;
  logic [WIDTH-1:0] In_real;
  logic [WIDTH-1:0] In_img;

  logic             Out_en;
  logic [WIDTH-1:0] Out_real;
  logic [WIDTH-1:0] Out_img;
  logic [LOG2N-1:0] Out_idx;
  logic             Out_last;

  modport master (
    output In_en, In_real, In_img,
    input  Out_en, Out_real, Out_img, Out_idx, Out_last
  );

  modport slave (
    input  In_en, In_real, In_img,
    output Out_en, Out_real, Out_img, Out_idx, Out_last
  );

endinterface

// File: rtl/fft_reorder_ram.sv
// ---------------------------------------------------------------------------
// fft_reorder_ram
// Simple dual-port RAM backing the ping-pong frame buffer.
// Address is {bank, index}; one write port, one synchronous read port.
//   clk   : clock
//   we    : write enable,  waddr/wdata : write address/data
//   re    : read enable,   raddr       : read address
//   rdata : read data, valid the cycle after re
// ---------------------------------------------------------------------------
module fft_reorder_ram
  import fft_pkg::*;
#(
  parameter int DW = 2 * SAMPLE_WIDTH,
  parameter int AW = LOG2N + 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  // NOTE: the storage array and its read register carry no reset; a reset
  // would stop the array mapping onto block RAM, and every location is
  // written before the reader is allowed to look at it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft64_out_reorder.sv
// ---------------------------------------------------------------------------
// fft64_out_reorder
// Buffers each bit-reversed FFT frame from the SDF chain and re-emits it in
// natural bin order (0..FFT_POINTS-1). Two banks are used ping-pong so
// back-to-back frames stream without stalls.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : fft64_out_reorder_if.slave (In_* in, Out_* out)
// Latency: the edge after the last input sample issues read address 0; bin 0
// appears with Out_en=1 one edge after that.
// ---------------------------------------------------------------------------
module fft64_out_reorder #(
  parameter int WIDTH      = 16,
  parameter int FFT_POINTS = 64,
  parameter int LOG2N      = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  fft64_out_reorder_if.slave   bus
);

  import fft_pkg::rd_state_e;
  import fft_pkg::RD_IDLE;
  import fft_pkg::RD_READ;
  import fft_pkg::bitrev;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(FFT_POINTS - 1);
  localparam int               DW       = 2 * WIDTH;

  // ---------------- write side ----------------
  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic             frame_done;

  // Raised during the cycle whose edge accepts the last sample of a frame;
  // the filled bank id is wr_bank until that edge toggles it.
  assign frame_done = bus.In_en && (wr_cnt == LAST_IDX);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (bus.In_en) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (frame_done) begin
        wr_bank <= ~wr_bank;
      end
    end
  end

  // ---------------- read FSM ----------------
  rd_state_e        state, state_nxt;
  logic [LOG2N-1:0] rd_cnt, rd_cnt_nxt;
  logic             rd_bank, rd_bank_nxt;
  logic             rd_en;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RD_IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_cnt  <= rd_cnt_nxt;
      rd_bank <= rd_bank_nxt;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    rd_cnt_nxt  = rd_cnt;
    rd_bank_nxt = rd_bank;
    rd_en       = 1'b0;
    unique case (state)
      RD_IDLE: begin
        if (frame_done) begin
          state_nxt   = RD_READ;
          rd_cnt_nxt  = '0;
          rd_bank_nxt = wr_bank;
        end
      end
      RD_READ: begin
        rd_en = 1'b1;
        if (rd_cnt == LAST_IDX) begin
          // A frame completing on the edge that issues the final address
          // chains straight into the next bank with no idle cycle.
          if (frame_done) begin
            state_nxt   = RD_READ;
            rd_cnt_nxt  = '0;
            rd_bank_nxt = wr_bank;
          end else begin
            state_nxt  = RD_IDLE;
            rd_cnt_nxt = '0;
          end
        end else begin
          rd_cnt_nxt = rd_cnt + 1'b1;
        end
      end
      default: state_nxt = RD_IDLE;
    endcase
  end

  // ---------------- frame buffer ----------------
  logic [DW-1:0] rd_data;

  fft_reorder_ram #(
    .DW (DW),
    .AW (LOG2N + 1)
  ) u_ram (
    .clk   (clk),
    .we    (bus.In_en),
    .waddr ({wr_bank, bitrev(wr_cnt, LOG2N)}),
    .wdata ({bus.In_real, bus.In_img}),
    .re    (rd_en),
    .raddr ({rd_bank, rd_cnt}),
    .rdata (rd_data)
  );

  // ---------------- output pipeline ----------------
  // rd_vld/rd_idx travel alongside the one-cycle RAM read.
  logic             rd_vld;
  logic [LOG2N-1:0] rd_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld       <= 1'b0;
      rd_idx       <= '0;
      bus.Out_en   <= 1'b0;
      bus.Out_last <= 1'b0;
      bus.Out_real <= '0;
      bus.Out_img  <= '0;
      bus.Out_idx  <= '0;
    end else begin
      rd_vld       <= rd_en;
      if (rd_en) begin
        rd_idx <= rd_cnt;
      end
      bus.Out_en   <= rd_vld;
      bus.Out_last <= rd_vld && (rd_idx == LAST_IDX);
      // Data and index hold their last values while Out_en is low.
      if (rd_vld) begin
        bus.Out_real <= rd_data[DW-1:WIDTH];
        bus.Out_img  <= rd_data[WIDTH-1:0];
        bus.Out_idx  <= rd_idx;
      end
    end
  end

endmodule

// File: tb/tb_fft64_out_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft64_out_reorder
// Directed bench for fft64_out_reorder: reset behaviour, single frame,
// back-to-back frames, gapped input, reset mid-frame and reset mid-readout.
// Output samples are logged by a negedge monitor and checked afterwards.
// ---------------------------------------------------------------------------
module tb_fft64_out_reorder;

  localparam int W  = 16;
  localparam int N  = 64;
  localparam int LG = 6;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  fft64_out_reorder_if #(.WIDTH(W), .LOG2N(LG)) bus ();

  fft64_out_reorder #(
    .WIDTH      (W),
    .FFT_POINTS (N),
    .LOG2N      (LG)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    int         idx;
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic       last;
  } rec_t;

  rec_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.Out_en === 1'b1) begin
      q.push_back('{cyc, int'(bus.Out_idx), bus.Out_real, bus.Out_img, bus.Out_last});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rev6(input int k);
    int r;
    r = 0;
    for (int i = 0; i < LG; i++) begin
      if (k[i]) r |= (1 << (LG - 1 - i));
    end
    return r;
  endfunction

  task automatic step(input logic en, input logic [W-1:0] re, input logic [W-1:0] im);
    @(negedge clk);
    bus.In_en   = en;
    bus.In_real = re;
    bus.In_img  = im;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0);
  endtask

  // e = cycle number of the edge that accepts the last sample.
  task automatic send_frame(input int base, input bit gapped, output int e);
    e = 0;
    for (int n = 0; n < N; n++) begin
      step(1'b1, W'(base + n), W'(-(base + n)));
      e = cyc + 1;
      if (gapped) step(1'b0, '0, '0);
    end
  endtask

  task automatic check_frame(input int start, input int base, input string tag);
    logic [W-1:0] er;
    logic [W-1:0] ei;
    if (q.size() < start + N) return;
    for (int k = 0; k < N; k++) begin
      er = W'(base + rev6(k));
      ei = -er;
      check({tag, "_idx"},  64'(q[start+k].idx), 64'(k));
      check({tag, "_real"}, 64'(q[start+k].re),  64'(er));
      check({tag, "_img"},  64'(q[start+k].im),  64'(ei));
      check({tag, "_last"}, 64'(q[start+k].last), 64'(k == N - 1));
    end
  endtask

  task automatic check_burst(input int len, input int e, input string tag);
    check({tag, "_count"}, 64'(q.size()), 64'(len));
    if (q.size() == len) begin
      check({tag, "_start"}, 64'(q[0].cyc), 64'(e + 2));
      check({tag, "_span"},  64'(q[len-1].cyc - q[0].cyc), 64'(len - 1));
    end
  endtask

  initial begin
    int e, ea, eb, n999;
    bit hit;

    bus.In_en   = 1'b0;
    bus.In_real = '0;
    bus.In_img  = '0;

    // ---- reset held with random input activity ----
    #1 reset = 1'b0;
    repeat (16) begin
      @(negedge clk);
      check("rst_outputs_zero",
            64'({bus.Out_en, bus.Out_last, bus.Out_idx, bus.Out_real, bus.Out_img}), 64'(0));
      bus.In_en   = 1'($urandom_range(0, 1));
      bus.In_real = W'($urandom);
      bus.In_img  = W'($urandom);
    end
    @(negedge clk);
    bus.In_en = 1'b0;
    reset     = 1'b1;
    idle(80);
    check("rst_no_output", 64'(q.size()), 64'(0));

    // ---- single contiguous frame ----
    send_frame(0, 1'b0, e);
    idle(70);
    check_burst(N, e, "single");
    if (q.size() == N) begin
      check("single_k1_real",  64'(q[1].re),  64'(32));
      check("single_k3_real",  64'(q[3].re),  64'(48));
      check("single_k63_real", 64'(q[63].re), 64'(63));
      check("single_k1_img",   64'(q[1].im),  64'(16'hFFE0));
    end
    check_frame(0, 0, "single");
    q.delete();

    // ---- back-to-back frames ----
    send_frame(0, 1'b0, ea);
    send_frame(100, 1'b0, eb);
    idle(140);
    check_burst(2 * N, ea, "b2b");
    if (q.size() == 2 * N) begin
      check("b2b_second_start", 64'(q[N].cyc), 64'(eb + 2));
      check("b2b_k1_real",      64'(q[N+1].re), 64'(132));
      check("b2b_last64",       64'(q[63].last), 64'(1));
      check("b2b_last128",      64'(q[127].last), 64'(1));
    end
    check_frame(0, 0, "b2b_a");
    check_frame(N, 100, "b2b_b");
    q.delete();

    // ---- gapped input ----
    send_frame(0, 1'b1, e);
    idle(70);
    check_burst(N, e, "gap");
    check_frame(0, 0, "gap");
    q.delete();

    // ---- reset in the middle of a frame ----
    for (int n = 0; n < 20; n++) step(1'b1, W'(999), W'(-999));
    @(negedge clk);
    bus.In_en = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    send_frame(0, 1'b0, e);
    idle(70);
    check_burst(N, e, "midrst");
    n999 = 0;
    foreach (q[i]) if (q[i].re == W'(999)) n999++;
    check("midrst_no_999", 64'(n999), 64'(0));
    check_frame(0, 0, "midrst");
    q.delete();

    // ---- reset during readout ----
    send_frame(0, 1'b0, e);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      bus.In_en = 1'b0;
      if (bus.Out_en === 1'b1 && bus.Out_idx == LG'(10)) hit = 1'b1;
    end
    check("rdrst_bin10_reached", 64'(hit), 64'(1));
    #1 reset = 1'b0;
    #1;
    check("rdrst_en_drop",   64'(bus.Out_en),   64'(0));
    check("rdrst_last_zero", 64'(bus.Out_last), 64'(0));
    check("rdrst_idx_zero",  64'(bus.Out_idx),  64'(0));
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    idle(10);
    check("rdrst_no_resume", 64'(q.size()), 64'(0));
    send_frame(50, 1'b0, e);
    idle(70);
    check_burst(N, e, "rdrst_new");
    if (q.size() == N) begin
      check("rdrst_bin0_idx",  64'(q[0].idx), 64'(0));
      check("rdrst_bin0_real", 64'(q[0].re),  64'(50));
      check("rdrst_bin0_img",  64'(q[0].im),  64'(16'hFFCE));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft64_out_reorder.md
Name: fft64_out_reorder

Overview:
- Output-side companion to the 64-point radix-2^2 SDF FFT chain.
- The SDF chain emits each 64-sample frame in bit-reversed bin order. This block buffers each frame and re-emits it in natural bin order (bin 0..63).
- It sits directly after the last SDF stage and drives the FFT output interface.
- Internally it uses a ping-pong (double) buffer, so back-to-back frames stream with no stall.

Parameters:
- WIDTH, 16, bit width of each real/imag sample (two's complement, passed through unmodified).
- FFT_POINTS, 64, frame length; must equal 2**LOG2N.
- LOG2N, 6, address/index width.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- In_en  input  1  input sample valid; one sample accepted per rising edge while high.
- In_real  input  WIDTH  real part, bit-reversed frame order.
- In_img  input  WIDTH  imag part, bit-reversed frame order.
- Out_en  output  1  output sample valid.
- Out_real  output  WIDTH  real part, natural bin order.
- Out_img  output  WIDTH  imag part, natural bin order.
- Out_idx  output  LOG2N  bin index of the current output sample.
- Out_last  output  1  high with bin FFT_POINTS-1 of each frame.

Behaviour:
- Reset (reset=0, async):
  - All outputs go to 0 immediately: Out_en, Out_last, Out_real, Out_img, Out_idx.
  - wr_cnt=0, wr_bank=0, rd state=IDLE, rd_cnt=0, pending flag cleared.
  - RAM contents are don't-care.
- Write side:
  - On each edge with In_en=1, {In_real,In_img} is written to bank wr_bank at address bitrev(wr_cnt). For LOG2N=6, bitrev maps b5..b0 to b0..b5.
  - wr_cnt then increments mod FFT_POINTS.
  - In_en=0 holds wr_cnt; gaps of any length are allowed.
  - On the edge that writes wr_cnt=FFT_POINTS-1: wr_bank toggles, and a one-cycle frame_done is raised carrying the filled bank id.
- Read FSM (IDLE, READ):
  - IDLE -> READ on frame_done: rd_bank = filled bank, rd_cnt = 0.
  - READ: RAM read address = rd_cnt; rd_cnt increments every cycle (no backpressure).
  - READ -> IDLE after issuing address FFT_POINTS-1, unless a new frame_done occurs on that same edge. In that case go straight to READ of the new bank with rd_cnt=0, giving a gap-free stream.
- RAM read is synchronous (1 cycle). Out_* are registered from RAM data, with Out_idx and Out_last delayed to align with the data.
- Latency:
  - Edge E accepts the last sample of a frame.
  - Edge E+1 issues read address 0.
  - Edge E+2 presents bin 0 with Out_en=1.
  - Out_en stays high for exactly FFT_POINTS consecutive cycles per frame.
- Out_en=0 cycles: Out_real, Out_img and Out_idx hold their last values; Out_last=0.
- Bank safety: input rate is at most 1 sample/cycle, so the next frame completes no earlier than edge E+64. Reader is finished with a bank before the writer re-enters it. No overflow condition exists and none is flagged.
- Reset mid-frame: the partial frame is discarded. The first FFT_POINTS samples accepted after reset release form frame 0.
- Reset during READ: output is aborted immediately (Out_en=0 asynchronously); no resumption.

Decomposition:
- Shared package fft_pkg:
  - constants FFT_POINTS=64, LOG2N=6;
  - function bitrev(idx, LOG2N);
  - sample typedef {real, imag} of WIDTH each.
- Sub-module fft_reorder_ram:
  - simple dual-port, 2*FFT_POINTS x 2*WIDTH;
  - one write port and one synchronous read port;
  - address = {bank, index}.

Test Plan:
- Reset: hold reset=0 with random In_en/In_real -> all outputs 0, Out_en never 1. Release, then drive no input -> Out_en stays 0.
- Single frame: 64 contiguous samples, In_real=n, In_img=-n for n=0..63.
  - Out_en high exactly 64 cycles, starting 2 edges after last input.
  - At Out_idx=k, Out_real=bitrev(k): k=1->32, k=3->48, k=63->63.
  - Out_img is the negation of that value.
  - Out_last only at k=63.
- Back-to-back frames: 128 contiguous samples, frame A real=n, frame B real=100+n.
  - 128 contiguous Out_en cycles.
  - Second frame k=1 -> 132.
  - Out_last at cycles 64 and 128.
- Gapped input: In_en toggles every other cycle for one frame -> a single contiguous 64-cycle output burst, same values as the single-frame test.
- Reset mid-frame: 20 samples (real=999), reset pulse, then a full frame real=n -> exactly one 64-sample output frame containing no 999.
- Reset during readout: assert reset at output bin 10 -> Out_en drops the same cycle. After release plus a new frame, bin 0 output is correct.
